// File: rtl/hazard_controller_pkg.sv
// Shared types for the pipeline hazard controller.
//   hz_state_t : sequencing FSM states
//   hz_ctrl_t  : the seven per-cycle pipeline register controls
//   HZ_X0      : architectural zero register index (never a real hazard source)
package hazard_controller_pkg;

  typedef enum logic [1:0] {
    RUN,
    LOAD_STALL,
    MEM_WAIT
  } hz_state_t;

  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_stall;
    logic idex_flush;
    logic exmem_stall;
    logic memwb_flush;
  } hz_ctrl_t;

  localparam logic [4:0] HZ_X0 = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
//   clk, reset : clock and asynchronous active-high reset (clears count)
//   en         : count this cycle
//   count      : current value, sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (en && (count_q != '1)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller for the 5-stage core: produces stall/flush controls for the
// PC and pipeline registers from load-use hazards, EX redirects and data-memory waits.
//   clk, reset                : clock, asynchronous active-high reset
//   id_rs1/rs2, id_uses_rs1/2 : source operands of the ID instruction
//   ex_mem_read, ex_rd        : EX instruction is a load, and its destination
//   ex_redirect               : taken branch / jump resolved in EX
//   mem_req, mem_ready        : data memory handshake of the MEM stage
//   *_stall, *_flush          : pipeline register controls for this cycle
//   stall_cycles              : saturating count of cycles with pc_stall
//   flush_events              : saturating count of redirect flushes
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             exmem_stall,
  output logic             memwb_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  // Remaining bubbles to insert after the hazard-detect cycle.
  localparam logic [2:0] BubInit = 3'(LOAD_BUBBLES - 1);

  hz_state_t state_q, state_d;
  hz_state_t adv_state;
  logic [2:0] bub_q, bub_d;
  hz_ctrl_t  ctrl, ctrl_out;
  logic      mem_wait, load_use, redirect_taken;

  assign mem_wait = mem_req & ~mem_ready;
  assign load_use = ex_mem_read & (ex_rd != HZ_X0) &
                    ((id_uses_rs1 & (ex_rd == id_rs1)) | (id_uses_rs2 & (ex_rd == id_rs2)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      bub_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
    end
  end

  always_comb begin
    ctrl           = '0;
    state_d        = RUN;
    bub_d          = bub_q;
    redirect_taken = 1'b0;
    // Leaving a memory wait picks up whatever was interrupted: pending bubbles or normal flow.
    adv_state      = state_q;
    if (state_q == MEM_WAIT) begin
      adv_state = (bub_q != 3'd0) ? LOAD_STALL : RUN;
    end

    if (mem_wait) begin
      // Freeze everything up to EX/MEM; drain a bubble into WB. Redirects wait for the memory.
      ctrl.pc_stall    = 1'b1;
      ctrl.ifid_stall  = 1'b1;
      ctrl.idex_stall  = 1'b1;
      ctrl.exmem_stall = 1'b1;
      ctrl.memwb_flush = 1'b1;
      state_d          = MEM_WAIT;
    end else if (ex_redirect) begin
      ctrl.ifid_flush = 1'b1;
      ctrl.idex_flush = 1'b1;
      redirect_taken  = 1'b1;
      bub_d           = 3'd0;
    end else if (adv_state == LOAD_STALL) begin
      ctrl.pc_stall   = 1'b1;
      ctrl.ifid_stall = 1'b1;
      ctrl.idex_flush = 1'b1;
      if (bub_q == 3'd1) begin
        bub_d = 3'd0;
      end else begin
        state_d = LOAD_STALL;
        bub_d   = bub_q - 3'd1;
      end
    end else if (load_use) begin
      ctrl.pc_stall   = 1'b1;
      ctrl.ifid_stall = 1'b1;
      ctrl.idex_flush = 1'b1;
      if (LOAD_BUBBLES > 1) begin
        state_d = LOAD_STALL;
        bub_d   = BubInit;
      end else begin
        bub_d = 3'd0;
      end
    end else begin
      bub_d = 3'd0;
    end
  end

  // While in reset the pipeline registers are held cleared and nothing is stalled.
  always_comb begin
    ctrl_out = ctrl;
    if (reset) begin
      ctrl_out             = '0;
      ctrl_out.ifid_flush  = 1'b1;
      ctrl_out.idex_flush  = 1'b1;
      ctrl_out.memwb_flush = 1'b1;
    end
  end

  assign pc_stall    = ctrl_out.pc_stall;
  assign ifid_stall  = ctrl_out.ifid_stall;
  assign ifid_flush  = ctrl_out.ifid_flush;
  assign idex_stall  = ctrl_out.idex_stall;
  assign idex_flush  = ctrl_out.idex_flush;
  assign exmem_stall = ctrl_out.exmem_stall;
  assign memwb_flush = ctrl_out.memwb_flush;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .en   (ctrl.pc_stall),
    .count(stall_cycles)
  );

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_flush_cnt (
    .clk  (clk),
    .reset(reset),
    .en   (redirect_taken),
    .count(flush_events)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: three instances (LOAD_BUBBLES 1/3/7, the last with 4-bit
// counters) share one stimulus stream and are checked every cycle against a model that only
// tracks "bubbles still owed" and counter totals.
module tb_hazard_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, ex_mem_read = 1'b0;
  logic       ex_redirect = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;

  // Control bits packed as {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
  // exmem_stall, memwb_flush}.
  logic [6:0]  c0, c1, c2;
  logic [31:0] s0, f0, s1, f1;
  logic [3:0]  s2, f2;

  int     total = 0;
  int     bad = 0;
  int     pend [3];
  longint sc_m [3];
  longint fe_m [3];

  always #5 clk = ~clk;

  hazard_controller #(.LOAD_BUBBLES(1), .CNT_W(32)) u0 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(c0[6]), .ifid_stall(c0[5]), .ifid_flush(c0[4]), .idex_stall(c0[3]),
    .idex_flush(c0[2]), .exmem_stall(c0[1]), .memwb_flush(c0[0]),
    .stall_cycles(s0), .flush_events(f0));

  hazard_controller #(.LOAD_BUBBLES(3), .CNT_W(32)) u1 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(c1[6]), .ifid_stall(c1[5]), .ifid_flush(c1[4]), .idex_stall(c1[3]),
    .idex_flush(c1[2]), .exmem_stall(c1[1]), .memwb_flush(c1[0]),
    .stall_cycles(s1), .flush_events(f1));

  hazard_controller #(.LOAD_BUBBLES(7), .CNT_W(4)) u2 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(c2[6]), .ifid_stall(c2[5]), .ifid_flush(c2[4]), .idex_stall(c2[3]),
    .idex_flush(c2[2]), .exmem_stall(c2[1]), .memwb_flush(c2[0]),
    .stall_cycles(s2), .flush_events(f2));

  function automatic int lb_of(int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 7);
  endfunction

  function automatic longint max_of(int i);
    return (i == 2) ? 64'd15 : 64'hFFFF_FFFF;
  endfunction

  function automatic logic [6:0] act_ctrl(int i);
    return (i == 0) ? c0 : ((i == 1) ? c1 : c2);
  endfunction

  function automatic logic [63:0] act_sc(int i);
    return (i == 0) ? {32'd0, s0} : ((i == 1) ? {32'd0, s1} : {60'd0, s2});
  endfunction

  function automatic logic [63:0] act_fe(int i);
    return (i == 0) ? {32'd0, f0} : ((i == 1) ? {32'd0, f1} : {60'd0, f2});
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare all instances against the model for the current cycle, then advance the model to
  // the state it must hold after the coming rising edge.
  task automatic check_cycle();
    logic [6:0] e;
    int         np;
    bit         lu, mw;
    lu = ex_mem_read && (ex_rd != 5'd0) &&
         ((id_uses_rs1 && ex_rd == id_rs1) || (id_uses_rs2 && ex_rd == id_rs2));
    mw = mem_req && !mem_ready;
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        pend[i] = 0;
        sc_m[i] = 0;
        fe_m[i] = 0;
      end
      chk($sformatf("u%0d stall_cycles", i), act_sc(i), sc_m[i]);
      chk($sformatf("u%0d flush_events", i), act_fe(i), fe_m[i]);
      if (reset) begin
        e = 7'b0010101; np = 0;
      end else if (mw) begin
        e = 7'b1101011; np = pend[i];
      end else if (ex_redirect) begin
        e = 7'b0010100; np = 0;
      end else if (pend[i] > 0) begin
        e = 7'b1100100; np = pend[i] - 1;
      end else if (lu) begin
        e = 7'b1100100; np = lb_of(i) - 1;
      end else begin
        e = 7'b0000000; np = 0;
      end
      chk($sformatf("u%0d ctrl", i), {57'd0, act_ctrl(i)}, {57'd0, e});
      if (!reset) begin
        pend[i] = np;
        if (e[6] && sc_m[i] < max_of(i)) sc_m[i]++;
        if (!mw && ex_redirect && fe_m[i] < max_of(i)) fe_m[i]++;
      end
    end
  endtask

  task automatic step();
    #1 check_cycle();
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_mem_read = 0; ex_redirect = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic load_use5();
    ex_mem_read = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    step();
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    @(negedge clk);
    step();
    chk("reset ctrl", {57'd0, c0}, 64'b0010101);
    @(negedge clk);
    reset = 0;

    // Single load-use: 1/3/7 stall cycles on the three instances.
    do_reset();
    load_use5();
    step();
    chk("lu ctrl", {57'd0, c0}, 64'b1100100);
    @(negedge clk);
    idle();
    step();
    chk("lu after", {57'd0, c0}, 64'd0);
    chk("lu stall_cycles", {32'd0, s0}, 64'd1);
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      step();
      @(negedge clk);
    end
    chk("lu3 stall_cycles", {32'd0, s1}, 64'd3);
    chk("lu7 stall_cycles", {60'd0, s2}, 64'd7);

    // Non-hazards: x0 destination, and rs2 match without rs2 use.
    do_reset();
    ex_mem_read = 1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1;
    step();
    chk("x0 no stall", {57'd0, c0}, 64'd0);
    @(negedge clk);
    ex_rd = 5'd5; id_rs1 = 5'd0; id_rs2 = 5'd5; id_uses_rs2 = 0;
    step();
    chk("rs2 unused no stall", {57'd0, c0}, 64'd0);
    @(negedge clk);
    id_uses_rs2 = 1;
    step();
    chk("rs2 used stall", {57'd0, c0}, 64'b1100100);
    @(negedge clk);

    // Redirect on the second bubble cancels the rest.
    do_reset();
    load_use5();
    step();
    chk("lb3 first bubble", {57'd0, c1}, 64'b1100100);
    @(negedge clk);
    idle();
    ex_redirect = 1;
    step();
    chk("lb3 redirect", {57'd0, c1}, 64'b0010100);
    @(negedge clk);
    idle();
    step();
    chk("lb3 after redirect", {57'd0, c1}, 64'd0);
    chk("lb3 flush_events", {32'd0, f1}, 64'd1);
    chk("lb3 stall_cycles", {32'd0, s1}, 64'd1);
    @(negedge clk);

    // Memory wait holding back a redirect.
    do_reset();
    mem_req = 1; ex_redirect = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("mem wait ctrl", {57'd0, c0}, 64'b1101011);
      @(negedge clk);
    end
    mem_ready = 1;
    step();
    chk("mem ready redirect", {57'd0, c0}, 64'b0010100);
    @(negedge clk);
    idle();
    step();
    chk("mem stall_cycles", {32'd0, s0}, 64'd4);
    chk("mem flush_events", {32'd0, f0}, 64'd1);
    @(negedge clk);

    // Asynchronous reset in the middle of the LOAD_BUBBLES=7 stall.
    do_reset();
    load_use5();
    step();
    @(negedge clk);
    idle();
    step();
    chk("u2 load stall", {57'd0, c2}, 64'b1100100);
    #1 reset = 1;
    #1;
    chk("reset mid stall ctrl", {57'd0, c2}, 64'b0010101);
    chk("reset mid stall cnt", {60'd0, s2}, 64'd0);
    step();
    @(negedge clk);
    reset = 0;
    step();
    chk("post reset ctrl", {57'd0, c2}, 64'd0);
    chk("post reset cnt", {60'd0, s2}, 64'd0);
    @(negedge clk);

    // 20 stall cycles saturate the 4-bit counter.
    do_reset();
    mem_req = 1;
    for (int k = 0; k < 20; k++) begin
      step();
      @(negedge clk);
    end
    idle();
    step();
    chk("sat stall_cycles 4b", {60'd0, s2}, 64'd15);
    chk("stall_cycles 32b", {32'd0, s0}, 64'd20);
    @(negedge clk);

    // Random traffic; small register indices make hazards frequent.
    for (int k = 0; k < 3000; k++) begin
      reset       = ($urandom_range(0, 199) == 0);
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      ex_rd       = 5'($urandom_range(0, 3));
      id_uses_rs1 = 1'($urandom_range(0, 1));
      id_uses_rs2 = 1'($urandom_range(0, 1));
      ex_mem_read = ($urandom_range(0, 99) < 40);
      ex_redirect = ($urandom_range(0, 99) < 12);
      mem_req     = ($urandom_range(0, 99) < 30);
      mem_ready   = ($urandom_range(0, 99) < 50);
      step();
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
